// File: rtl/btn_debounce.sv
// btn_debounce: push-button conditioner.
// Synchronises the raw button, debounces it with a stable-time counter and
// produces a debounced level, one-cycle press/release strobes and an enable
// level that toggles on every accepted press.
// Optional feature macro: BTN_AUTOREPEAT_EN (periodic press pulses while held).
// Note: "release" is a reserved word, so that port is named release_pulse.
module btn_debounce #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned DEB_CYCLES    = 500000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic en
);

  typedef enum logic [1:0] {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Parameter sanity checks at elaboration
  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("btn_debounce: SYNC_STAGES must be >= 2");
    end
    if (DEB_CYCLES < 1 || (64'(DEB_CYCLES) - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_cnt
      $error("btn_debounce: CNT_W cannot hold DEB_CYCLES-1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_rep
      $error("btn_debounce: REPEAT_CYCLES must be >= 1");
    end
  endgenerate

  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   level_d, press_d, release_d, en_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt, rep_cnt_d;
`endif

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser shift register on the asynchronous button input
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  // State register plus registered outputs and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE_LO;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      en            <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt       <= '0;
`endif
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      level         <= level_d;
      press         <= press_d;
      release_pulse <= release_d;
      en            <= en_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt       <= rep_cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE_LO: if (sync) state_d = CHK_HI;
      CHK_HI: begin
        if (!sync)                 state_d = IDLE_LO;
        else if (cnt == CNT_LAST)  state_d = IDLE_HI;
      end
      IDLE_HI: if (!sync) state_d = CHK_LO;
      CHK_LO: begin
        if (sync)                  state_d = IDLE_HI;
        else if (cnt == CNT_LAST)  state_d = IDLE_LO;
      end
      default: state_d = IDLE_LO;
    endcase
  end

  // Next values for the counters and registered outputs
  always_comb begin
    cnt_d     = cnt;
    level_d   = level;
    press_d   = 1'b0;
    release_d = 1'b0;
    en_d      = en;
`ifdef BTN_AUTOREPEAT_EN
    rep_cnt_d = '0;
`endif
    case (state)
      IDLE_LO: if (sync) cnt_d = '0;
      CHK_HI: begin
        if (!sync) begin
          cnt_d = '0;
        end else if (cnt == CNT_LAST) begin
          level_d = 1'b1;
          press_d = 1'b1;
          en_d    = ~en;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!sync) begin
          cnt_d = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        // Leaving IDLE_HI takes priority over a coincident repeat pulse
        else if (rep_cnt == REP_LAST) begin
          press_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt + REP_W'(1);
        end
`endif
      end
      CHK_LO: begin
        if (sync) begin
          cnt_d = '0;
        end else if (cnt == CNT_LAST) begin
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce (SYNC_STAGES=2, DEB_CYCLES=4, REPEAT_CYCLES=8).
// Stimulus pushes expected pulses (edge number, kind, en, level); a monitor
// pops one entry per observed press/release pulse and compares.
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst, btn;
  logic level, press, release_pulse, en;

  int edge_n = 0;
  int tests  = 0;
  int fails  = 0;
  bit en_m   = 1'b0;

  typedef struct {
    bit is_press;
    int at;
    bit en;
    bit level;
  } exp_t;

  exp_t sb[$];

  btn_debounce #(
    .SYNC_STAGES  (2),
    .CNT_W        (4),
    .DEB_CYCLES   (4),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .en           (en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: one scoreboard entry per observed pulse
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (press === 1'b1 && release_pulse === 1'b1) begin
      tests++;
      fails++;
      $display("FAIL overlap: press and release both high at edge %0d, required never together", edge_n);
    end
    if (press === 1'b1 || release_pulse === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: press=%b release=%b at edge %0d, required no pulse",
                 press, release_pulse, edge_n);
      end else begin
        e = sb.pop_front();
        if (press !== e.is_press || release_pulse !== !e.is_press || edge_n != e.at ||
            en !== e.en || level !== e.level) begin
          fails++;
          $display("FAIL pulse: got press=%b release=%b edge=%0d en=%b level=%b, required press=%b release=%b edge=%0d en=%b level=%b",
                   press, release_pulse, edge_n, en, level,
                   e.is_press, !e.is_press, e.at, e.en, e.level);
        end
      end
    end
  end

  task automatic check(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input bit is_p, input int after);
    exp_t e;
    e.is_press = is_p;
    e.at       = edge_n + after;
    e.en       = en_m;
    e.level    = is_p;
    sb.push_back(e);
  endtask

  task automatic press_now();
    btn  = 1'b1;
    en_m = ~en_m;
    expect_pulse(1'b1, 7);
    cyc(7);
  endtask

  task automatic release_now();
    btn = 1'b0;
    expect_pulse(1'b0, 7);
    cyc(7);
  endtask

  task automatic check_all_low(input string name);
    check({name, "_level"}, level, 1'b0);
    check({name, "_press"}, press, 1'b0);
    check({name, "_release"}, release_pulse, 1'b0);
    check({name, "_en"}, en, 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset with button held high, then press after reset exit
    rst = 1'b0;
    btn = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(1);
      check_all_low("reset");
    end
    rst = 1'b1;
    press_now();
    release_now();

    // 5. Reset during the second CHK_HI cycle
    btn = 1'b1;
    cyc(4);
    rst = 1'b0;
    btn = 1'b0;
    cyc(1);
    check_all_low("midchk_reset");
    en_m = 1'b0;
    rst  = 1'b1;
    cyc(10);
    check("midchk_level", level, 1'b0);
    check("midchk_en", en, 1'b0);

    // 2. Clean press with level boundary checks
    btn  = 1'b1;
    en_m = ~en_m;
    expect_pulse(1'b1, 7);
    cyc(6);
    check("clean_level_early", level, 1'b0);
    check("clean_en_early", en, 1'b0);
    cyc(1);
    check("clean_level", level, 1'b1);
    check("clean_en", en, 1'b1);
    release_now();
    check("after_release_en", en, 1'b1);

    // 3. Bounce rejection, ending with a glitch one sample before acceptance
    for (int unsigned i = 0; i < 5; i++) begin
      btn = 1'b1;
      cyc(3);
      btn = 1'b0;
      cyc(1);
    end
    btn = 1'b1;
    cyc(4);
    btn = 1'b0;
    cyc(10);
    check("bounce_level", level, 1'b0);
    check("bounce_en", en, en_m);

    // 4. Press, release, second press
    press_now();
    release_now();
    check("rel_en_kept", en, en_m);

    // 6. Held press with optional auto-repeat
    btn  = 1'b1;
    en_m = ~en_m;
    expect_pulse(1'b1, 7);
`ifdef BTN_AUTOREPEAT_EN
    expect_pulse(1'b1, 15);
    expect_pulse(1'b1, 23);
    expect_pulse(1'b1, 31);
    expect_pulse(1'b1, 39);
`endif
    cyc(40);
    check("hold_en", en, en_m);
    check("hold_level", level, 1'b1);
    release_now();
    cyc(10);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
